// File: rtl/interrupt_spr_unit_pkg.sv
// Shared constants for the interrupt/SPR unit: SPR addresses, cause bit
// positions and the split between maskable and non-maskable causes.
package interrupt_spr_unit_pkg;

  localparam int CA_W = 23;

  localparam logic [2:0] SPR_SR    = 3'd0;
  localparam logic [2:0] SPR_ESR   = 3'd1;
  localparam logic [2:0] SPR_ECA   = 3'd2;
  localparam logic [2:0] SPR_EPC   = 3'd3;
  localparam logic [2:0] SPR_EDATA = 3'd4;
  localparam logic [2:0] SPR_MODE  = 3'd5;

  localparam int CA_OVF       = 0;
  localparam int CA_SYSC      = 1;
  localparam int CA_MAL_LS    = 3;
  localparam int CA_ILLEGAL   = 4;
  localparam int CA_MAL_FETCH = 6;
  localparam int CA_EXT_LO    = 7;
  localparam int CA_EXT_HI    = 22;

  // Bits gated by SR; the remaining live causes always pass, 2 and 5 are reserved.
  localparam logic [CA_W-1:0] CA_MASKABLE = 23'h7FFF81;
  localparam logic [CA_W-1:0] CA_NONMASK  = 23'h00005A;

endpackage

// File: rtl/interrupt_priority.sv
// Combinational cause masking, priority selection and repeat classification.
import interrupt_spr_unit_pkg::*;

module interrupt_priority (
  input  logic [CA_W-1:0] i_ca,
  input  logic [CA_W-1:0] i_sr_mask,
  output logic [CA_W-1:0] o_mca,
  output logic            o_jisr,
  output logic [31:0]     o_il,
  output logic            o_rpt
);

  logic [CA_W-1:0] w_mca;
  logic [31:0]     w_il;

  assign w_mca = (i_ca & CA_MASKABLE & i_sr_mask) | (i_ca & CA_NONMASK);

  // Scan downward so the lowest set index wins.
  always_comb begin
    w_il = 32'd0;
    for (int k = CA_W - 1; k >= 0; k--) begin
      if (w_mca[k]) w_il = 32'd1 << k;
    end
  end

  assign o_mca  = w_mca;
  assign o_jisr = |w_mca;
  assign o_il   = w_il;
  assign o_rpt  = (|w_il[15:1]) | w_il[17] | w_il[20];

endmodule

// File: rtl/interrupt_spr_unit.sv
// Interrupt unit: cause masking/priority plus the SR/ESR/ECA/EPC/EDATA/MODE
// special-purpose register file, with interrupt entry overriding SPR writes.
import interrupt_spr_unit_pkg::*;

module interrupt_spr_unit (
  input  logic            clk,
  input  logic            rst,
  input  logic [CA_W-1:0] ca,
  input  logic [31:0]     pc,
  input  logic [31:0]     next_pc,
  input  logic [31:0]     ea,
  input  logic [31:0]     data_in,
  input  logic [2:0]      reg_sel,
  input  logic            sprw,
  output logic [CA_W-1:0] mca,
  output logic            jisr,
  output logic [31:0]     il,
  output logic            rpt,
  output logic [31:0]     spr_out,
  output logic [31:0]     sr,
  output logic [31:0]     mode
);

  logic [31:0] r_sr, r_esr, r_eca, r_epc, r_edata;
  logic        r_mode;

  logic [CA_W-1:0] w_mca;
  logic            w_jisr;
  logic [31:0]     w_il;
  logic            w_rpt;

  interrupt_priority u_priority (
    .i_ca      (ca),
    .i_sr_mask (r_sr[CA_W-1:0]),
    .o_mca     (w_mca),
    .o_jisr    (w_jisr),
    .o_il      (w_il),
    .o_rpt     (w_rpt)
  );

  // Interrupt entry takes precedence; a coincident SPR write is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr    <= 32'd0;
      r_esr   <= 32'd0;
      r_eca   <= 32'd0;
      r_epc   <= 32'd0;
      r_edata <= 32'd0;
      r_mode  <= 1'b0;
    end else if (w_jisr) begin
      r_esr   <= r_sr;
      r_sr    <= 32'd0;
      r_eca   <= {{(32-CA_W){1'b0}}, w_mca};
      r_epc   <= w_rpt ? pc : next_pc;
      r_edata <= ea;
      r_mode  <= 1'b0;
    end else if (sprw) begin
      case (reg_sel)
        SPR_SR:    r_sr    <= data_in;
        SPR_ESR:   r_esr   <= data_in;
        SPR_ECA:   r_eca   <= data_in;
        SPR_EPC:   r_epc   <= data_in;
        SPR_EDATA: r_edata <= data_in;
        SPR_MODE:  r_mode  <= data_in[0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    spr_out = 32'd0;
    case (reg_sel)
      SPR_SR:    spr_out = r_sr;
      SPR_ESR:   spr_out = r_esr;
      SPR_ECA:   spr_out = r_eca;
      SPR_EPC:   spr_out = r_epc;
      SPR_EDATA: spr_out = r_edata;
      SPR_MODE:  spr_out = {31'd0, r_mode};
      default:   spr_out = 32'd0;
    endcase
  end

  assign mca  = w_mca;
  assign jisr = w_jisr;
  assign il   = w_il;
  assign rpt  = w_rpt;
  assign sr   = r_sr;
  assign mode = {31'd0, r_mode};

endmodule

// File: tb/tb_interrupt_spr_unit.sv
// Directed bench for interrupt_spr_unit: reset, masking, repeat/continue
// entry, jisr-vs-sprw collision, MODE and unmapped SPR addresses.
module tb_interrupt_spr_unit;

  logic        clk;
  logic        rst;
  logic [22:0] ca;
  logic [31:0] pc, next_pc, ea, data_in;
  logic [2:0]  reg_sel;
  logic        sprw;
  logic [22:0] mca;
  logic        jisr;
  logic [31:0] il;
  logic        rpt;
  logic [31:0] spr_out, sr, mode;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_spr_unit dut (
    .clk     (clk),
    .rst     (rst),
    .ca      (ca),
    .pc      (pc),
    .next_pc (next_pc),
    .ea      (ea),
    .data_in (data_in),
    .reg_sel (reg_sel),
    .sprw    (sprw),
    .mca     (mca),
    .jisr    (jisr),
    .il      (il),
    .rpt     (rpt),
    .spr_out (spr_out),
    .sr      (sr),
    .mode    (mode)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spr_write(input logic [2:0] sel, input logic [31:0] d);
    reg_sel = sel;
    data_in = d;
    sprw    = 1'b1;
    tick();
    sprw    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ca      = 23'($urandom_range(0, 32'h7FFFFF));
      pc      = $urandom;
      next_pc = $urandom;
      ea      = $urandom;
      data_in = $urandom;
      sprw    = 1'($urandom_range(0, 1));
      reg_sel = 3'($urandom_range(0, 7));
      tick();
    end
    ca = 23'h000000;
    sprw = 1'b0;
    for (int s = 0; s < 8; s++) begin
      reg_sel = 3'(s);
      #1;
      n_checks++;
      if (spr_out !== 32'd0) begin
        $display("FAIL reset_spr_out sel=%0d got=%h exp=%h", s, spr_out, 32'd0);
        n_fail++;
      end
    end
    n_checks++;
    if (sr !== 32'd0) begin
      $display("FAIL reset_sr got=%h exp=%h", sr, 32'd0); n_fail++;
    end
    n_checks++;
    if (mode !== 32'd0) begin
      $display("FAIL reset_mode got=%h exp=%h", mode, 32'd0); n_fail++;
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_masking();
    ca = 23'h000001;
    #1;
    n_checks++;
    if (jisr !== 1'b0) begin
      $display("FAIL mask_jisr_off got=%b exp=%b", jisr, 1'b0); n_fail++;
    end
    spr_write(3'd0, 32'h1);
    n_checks++;
    if (sr !== 32'h1) begin
      $display("FAIL mask_sr_written got=%h exp=%h", sr, 32'h1); n_fail++;
    end
    n_checks++;
    if (mca !== 23'h000001) begin
      $display("FAIL mask_mca got=%h exp=%h", mca, 23'h000001); n_fail++;
    end
    n_checks++;
    if (jisr !== 1'b1) begin
      $display("FAIL mask_jisr_on got=%b exp=%b", jisr, 1'b1); n_fail++;
    end
    n_checks++;
    if (il !== 32'h1) begin
      $display("FAIL mask_il got=%h exp=%h", il, 32'h1); n_fail++;
    end
    n_checks++;
    if (rpt !== 1'b0) begin
      $display("FAIL mask_rpt got=%b exp=%b", rpt, 1'b0); n_fail++;
    end
    pc = 32'h10; next_pc = 32'h14; ea = 32'h0;
    tick();
    ca = 23'h0;
    reg_sel = 3'd1;
    #1;
    n_checks++;
    if (spr_out !== 32'h1) begin
      $display("FAIL mask_esr got=%h exp=%h", spr_out, 32'h1); n_fail++;
    end
    n_checks++;
    if (sr !== 32'h0) begin
      $display("FAIL mask_sr_cleared got=%h exp=%h", sr, 32'h0); n_fail++;
    end
  endtask

  task automatic test_repeat();
    spr_write(3'd5, 32'h1);
    ca = 23'h000008; pc = 32'h100; next_pc = 32'h104; ea = 32'h203;
    #1;
    n_checks++;
    if (il !== 32'h8 || rpt !== 1'b1) begin
      $display("FAIL rep_il_rpt got=%h/%b exp=%h/%b", il, rpt, 32'h8, 1'b1); n_fail++;
    end
    tick();
    ca = 23'h0;
    reg_sel = 3'd3; #1;
    n_checks++;
    if (spr_out !== 32'h100) begin
      $display("FAIL rep_epc got=%h exp=%h", spr_out, 32'h100); n_fail++;
    end
    reg_sel = 3'd2; #1;
    n_checks++;
    if (spr_out !== 32'h8) begin
      $display("FAIL rep_eca got=%h exp=%h", spr_out, 32'h8); n_fail++;
    end
    reg_sel = 3'd4; #1;
    n_checks++;
    if (spr_out !== 32'h203) begin
      $display("FAIL rep_edata got=%h exp=%h", spr_out, 32'h203); n_fail++;
    end
    n_checks++;
    if (mode !== 32'h0 || sr !== 32'h0) begin
      $display("FAIL rep_mode_sr got=%h/%h exp=%h/%h", mode, sr, 32'h0, 32'h0); n_fail++;
    end
  endtask

  task automatic test_continue();
    spr_write(3'd0, 32'hFFFF_FFFF);
    ca = 23'h000001; pc = 32'h40; next_pc = 32'h44; ea = 32'h0;
    #1;
    n_checks++;
    if (il !== 32'h1 || rpt !== 1'b0 || jisr !== 1'b1) begin
      $display("FAIL cont_il_rpt_jisr got=%h/%b/%b exp=%h/%b/%b", il, rpt, jisr, 32'h1, 1'b0, 1'b1);
      n_fail++;
    end
    tick();
    ca = 23'h0;
    reg_sel = 3'd3; #1;
    n_checks++;
    if (spr_out !== 32'h44) begin
      $display("FAIL cont_epc got=%h exp=%h", spr_out, 32'h44); n_fail++;
    end
    reg_sel = 3'd1; #1;
    n_checks++;
    if (spr_out !== 32'hFFFF_FFFF) begin
      $display("FAIL cont_esr got=%h exp=%h", spr_out, 32'hFFFF_FFFF); n_fail++;
    end
  endtask

  task automatic test_external();
    spr_write(3'd0, 32'h0050_0000);
    ca = 23'h500080;
    #1;
    n_checks++;
    if (mca !== 23'h500000 || il !== 32'h0010_0000 || rpt !== 1'b1) begin
      $display("FAIL ext_bit20 got=%h/%h/%b exp=%h/%h/%b", mca, il, rpt, 23'h500000, 32'h0010_0000, 1'b1);
      n_fail++;
    end
    ca = 23'h400080;
    #1;
    n_checks++;
    if (il !== 32'h0040_0000 || rpt !== 1'b0) begin
      $display("FAIL ext_bit22 got=%h/%b exp=%h/%b", il, rpt, 32'h0040_0000, 1'b0); n_fail++;
    end
    ca = 23'h0;
  endtask

  task automatic test_back_to_back();
    spr_write(3'd0, 32'h0000_0080);
    ca = 23'h000012; reg_sel = 3'd0; data_in = 32'h1234; sprw = 1'b1;
    pc = 32'h200; next_pc = 32'h204;
    #1;
    n_checks++;
    if (il !== 32'h2 || rpt !== 1'b1) begin
      $display("FAIL col_il_rpt got=%h/%b exp=%h/%b", il, rpt, 32'h2, 1'b1); n_fail++;
    end
    tick();
    sprw = 1'b0; ca = 23'h0;
    #1;
    n_checks++;
    if (sr !== 32'h0) begin
      $display("FAIL col_sr got=%h exp=%h", sr, 32'h0); n_fail++;
    end
    reg_sel = 3'd1; #1;
    n_checks++;
    if (spr_out !== 32'h80) begin
      $display("FAIL col_esr got=%h exp=%h", spr_out, 32'h80); n_fail++;
    end
    reg_sel = 3'd2; #1;
    n_checks++;
    if (spr_out !== 32'h12) begin
      $display("FAIL col_eca got=%h exp=%h", spr_out, 32'h12); n_fail++;
    end
    reg_sel = 3'd3; #1;
    n_checks++;
    if (spr_out !== 32'h200) begin
      $display("FAIL col_epc got=%h exp=%h", spr_out, 32'h200); n_fail++;
    end
  endtask

  task automatic test_mode();
    spr_write(3'd5, 32'hFFFF_FFFF);
    n_checks++;
    if (mode !== 32'h1) begin
      $display("FAIL mode_out got=%h exp=%h", mode, 32'h1); n_fail++;
    end
    reg_sel = 3'd5; #1;
    n_checks++;
    if (spr_out !== 32'h1) begin
      $display("FAIL mode_read got=%h exp=%h", spr_out, 32'h1); n_fail++;
    end
    spr_write(3'd6, 32'hDEAD_BEEF);
    spr_write(3'd7, 32'hCAFE_F00D);
    reg_sel = 3'd6; #1;
    n_checks++;
    if (spr_out !== 32'h0) begin
      $display("FAIL addr6_read got=%h exp=%h", spr_out, 32'h0); n_fail++;
    end
    reg_sel = 3'd7; #1;
    n_checks++;
    if (spr_out !== 32'h0) begin
      $display("FAIL addr7_read got=%h exp=%h", spr_out, 32'h0); n_fail++;
    end
    reg_sel = 3'd0; #1;
    n_checks++;
    if (spr_out !== 32'h0 || mode !== 32'h1) begin
      $display("FAIL unmapped_side_effect got=%h/%h exp=%h/%h", spr_out, mode, 32'h0, 32'h1); n_fail++;
    end
  endtask

  initial begin
    rst = 1'b0; ca = 23'h0; pc = 32'h0; next_pc = 32'h0; ea = 32'h0;
    data_in = 32'h0; reg_sel = 3'd0; sprw = 1'b0;
    test_reset();
    test_masking();
    test_repeat();
    test_continue();
    test_external();
    test_back_to_back();
    test_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_spr_unit.md
INTERRUPT_SPR_UNIT -- requirements
Module: interrupt_spr_unit

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock, rising edge) and rst (in, 1, asynchronous, active-low reset).
REQ-002 SHALL have ca (in, 23): cause vector; [0] ovf, [1] sysc, [3] misaligned load/store, [4] illegal, [6] misaligned fetch, [22:7] external, [2]/[5] reserved.
REQ-003 SHALL have pc and next_pc (in, 32): address of the current instruction and of its successor.
REQ-004 SHALL have ea (in, 32): effective address of the current instruction.
REQ-005 SHALL have data_in (in, 32), reg_sel (in, 3) and sprw (in, 1): SPR write data, register select and write enable.
REQ-006 SHALL have mca (out, 23): masked cause vector.
REQ-007 SHALL have jisr (out, 1): interrupt taken this cycle.
REQ-008 SHALL have il (out, 32): one-hot highest-priority pending cause.
REQ-009 SHALL have rpt (out, 1): repeat-type interrupt pending.
REQ-010 SHALL have spr_out (out, 32): SPR read data.
REQ-011 SHALL have sr (out, 32): status register.
REQ-012 SHALL have mode (out, 32): 0 = system mode, 1 = user mode.

Function
REQ-013 SHALL compute mca combinationally: maskable bits 0 and 22:7 as ca[j] AND sr[j]; bits 1, 3, 4 and 6 as ca[j] unmasked; bits 2 and 5 as constant 0.
REQ-014 SHALL drive jisr = OR-reduction of mca, combinationally.
REQ-015 SHALL set il[k]=1 only for the lowest k with mca[k]=1 (lowest index = highest priority); il[31:23] and all of il SHALL be 0 when no mca bit is set.
REQ-016 SHALL drive rpt = (il[15:1] != 0) OR il[17] OR il[20].
REQ-017 SHALL map SPR addresses as 0 SR, 1 ESR, 2 ECA, 3 EPC, 4 EDATA, 5 MODE; addresses 6 and 7 SHALL read 0 and ignore writes.
REQ-018 SHALL drive spr_out combinationally from reg_sel with no latency.
REQ-019 SHALL, on a rising edge with jisr=1: ESR <= SR; SR <= 0; ECA <= zero-extended mca; EPC <= pc if rpt else next_pc; EDATA <= ea; MODE <= 0.
REQ-020 SHALL, on a rising edge with jisr=0 and sprw=1, write data_in into the selected register; writes to MODE SHALL store only bit 0, and bits 31:1 SHALL read 0.
REQ-021 SHALL give jisr priority over sprw when both occur in one cycle, discarding the write.
REQ-022 SHALL make written or updated values visible on sr, mode and spr_out in the cycle after the edge.

Reset
REQ-023 SHALL, while rst=0, asynchronously clear SR, ESR, ECA, EPC, EDATA and MODE to 0, giving sr=0, mode=0 and spr_out=0.
REQ-024 SHALL, because SR=0 out of reset, have all maskable causes masked; mca and jisr SHALL respond only to bits 1, 3, 4 and 6.

Structure
REQ-025 SHALL place SPR address constants, cause bit indices and the maskable-bit mask (23'h7FFF81) in a shared package.
REQ-026 SHALL implement REQ-013..REQ-016 in a combinational sub-module named interrupt_priority; the SPR register file SHALL sit in the top module.

Verification
REQ-027 SHALL cover reset: rst=0 with all inputs toggling -> sr=0, mode=0, spr_out=0 for every reg_sel.
REQ-028 SHALL cover masking: SR=0, ca=23'h000001 -> jisr=0; then write SR=1 via sprw -> next cycle mca=1, jisr=1, il=1, rpt=0.
REQ-029 SHALL cover a repeat interrupt: ca bit 3 set, pc=0x100, next_pc=0x104, ea=0x203 -> after the edge EPC=0x100, ECA=0x8, EDATA=0x203, MODE=0, SR=0.
REQ-030 SHALL cover a continue interrupt: SR=0xFFFFFFFF, ca bit 0 only, pc=0x40, next_pc=0x44 -> EPC=0x44 and ESR=0xFFFFFFFF.
REQ-031 SHALL cover priority and collision: ca = bits 1 and 4, sprw=1 to SR -> il=0x2, rpt=1, SR cleared and the write discarded.
REQ-032 SHALL cover the MODE write: sprw to MODE with data 0xFFFFFFFF -> mode=1; a read of address 6 -> 0.
